sisc_ctrl: RTL and testbench

Multi-cycle control unit for the SISC processor. It is the initiator side of the ALU interface: it decodes the instruction register and drives `alu_op`, PC, IR, register-file and data-memory controls through a fixed state sequence. It consumes the 4-bit status word (C,V,N,Z) held by the status register to resolve conditional branches.

---
 rtl/sisc_pkg.sv | 70 +++++++
 rtl/sisc_br_eval.sv | 33 +++
 rtl/sisc_ctrl.sv | 138 +++++++++++++
 tb/tb_sisc_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared opcode, state, alu_op and status-bit definitions for the SISC control path.
// SISC_BRANCH_NOT_EN adds the inverted-condition branches BNR/BNA.
package sisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_BRR  = 4'h4;
  localparam logic [3:0] OP_BRA  = 4'h5;
  localparam logic [3:0] OP_BNR  = 4'h6;
  localparam logic [3:0] OP_BNA  = 4'h7;
  localparam logic [3:0] OP_LOD  = 4'h8;
  localparam logic [3:0] OP_STR  = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_START0  = 3'd0,
    ST_START1  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_MEM     = 3'd5,
    ST_WBACK   = 3'd6,
    ST_HALTED  = 3'd7
  } state_t;

  localparam logic [1:0] ALUOP_REG    = 2'b00;
  localparam logic [1:0] ALUOP_IMM    = 2'b01;
  localparam logic [1:0] ALUOP_ADDR   = 2'b11;
  localparam logic [1:0] ALUOP_NOSAVE = 2'b10;

  localparam int STAT_C = 3;
  localparam int STAT_V = 2;
  localparam int STAT_N = 1;
  localparam int STAT_Z = 0;

  function automatic logic is_branch(input logic [3:0] op);
    logic r;
    r = (op == OP_BRR) || (op == OP_BRA);
`ifdef SISC_BRANCH_NOT_EN
    r = r || (op == OP_BNR) || (op == OP_BNA);
`endif
    return r;
  endfunction

  function automatic logic is_abs_branch(input logic [3:0] op);
    logic r;
    r = (op == OP_BRA);
`ifdef SISC_BRANCH_NOT_EN
    r = r || (op == OP_BNA);
`endif
    return r;
  endfunction

  // Opcodes that need the ALU, i.e. leave DECODE for EXECUTE.
  function automatic logic is_exec(input logic [3:0] op);
    return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LOD) || (op == OP_STR);
  endfunction

  function automatic logic [1:0] exec_aluop(input logic [3:0] op);
    logic [1:0] r;
    case (op)
      OP_ADDI:        r = ALUOP_IMM;
      OP_LOD, OP_STR: r = ALUOP_ADDR;
      default:        r = ALUOP_REG;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sisc_br_eval.sv
// Branch condition evaluator: taken when any masked status bit is set (mm==0 = always).
// With SISC_BRANCH_NOT_EN, BNR/BNA are taken when no masked bit is set (mm==0 = never).
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int OPW = 4,
  parameter int MMW = 4
) (
  input  logic [OPW-1:0] i_op,
  input  logic [MMW-1:0] i_mm,
  input  logic [MMW-1:0] i_stat,
  output logic           o_taken
);

  logic w_any;
  logic w_mm_zero;

  // mm bit i selects status bit i, so mm[STAT_Z] tests Z, mm[STAT_C] tests C.
  assign w_any     = |(i_mm & i_stat);
  assign w_mm_zero = (i_mm == '0);

  always_comb begin
    o_taken = 1'b0;
    case (i_op)
      OP_BRR, OP_BRA: o_taken = w_mm_zero || w_any;
`ifdef SISC_BRANCH_NOT_EN
      OP_BNR, OP_BNA: o_taken = !w_mm_zero && !w_any;
`endif
      default:        o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle controller: FSM sequencing PC/IR/ALU/regfile/dmem controls from the IR opcode.
// Outputs are decoded combinationally from (state, op); SISC_BRANCH_NOT_EN enables BNR/BNA.
module sisc_ctrl
  import sisc_pkg::*;
#(
  parameter int OPW = 4,
  parameter int MMW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [3:0]  stat,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_rst,
  output logic        pc_sel,
  output logic        br_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        mm_sel,
  output logic        dm_we,
  output logic        halt
);

  state_t r_state;
  state_t w_next;

  logic [OPW-1:0] w_op;
  logic [MMW-1:0] w_mm;
  logic           w_taken;
  logic           w_is_lod;
  logic           w_is_str;
  logic [1:0]     w_exec_aluop;
  logic           w_unused_instr;

  assign w_op         = instr[31 -: OPW];
  assign w_mm         = instr[27 -: MMW];
  assign w_is_lod     = (w_op == OP_LOD);
  assign w_is_str     = (w_op == OP_STR);
  assign w_exec_aluop = exec_aluop(w_op);

  // Immediate/funct fields feed the datapath, not the controller.
  assign w_unused_instr = &{1'b0, instr[23:0]};

  sisc_br_eval #(
    .OPW (OPW),
    .MMW (MMW)
  ) u_br_eval (
    .i_op    (w_op),
    .i_mm    (w_mm),
    .i_stat  (stat),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_START0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_START0:  w_next = ST_START1;
      ST_START1:  w_next = ST_FETCH;
      ST_FETCH:   w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_op == OP_HLT) begin
          w_next = ST_HALTED;
        end else if (is_exec(w_op)) begin
          w_next = ST_EXECUTE;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_EXECUTE: w_next = (w_is_lod || w_is_str) ? ST_MEM : ST_WBACK;
      ST_MEM:     w_next = w_is_lod ? ST_WBACK : ST_FETCH;
      ST_WBACK:   w_next = ST_FETCH;
      ST_HALTED:  w_next = ST_HALTED;
      default:    w_next = ST_START0;
    endcase
  end

  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    alu_op   = ALUOP_REG;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    mm_sel   = 1'b0;
    dm_we    = 1'b0;
    halt     = 1'b0;
    case (r_state)
      ST_START0, ST_START1: begin
        pc_rst = 1'b1;
      end
      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      ST_DECODE: begin
        // w_taken is only ever set for branch opcodes.
        if (w_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = is_abs_branch(w_op);
        end
      end
      ST_EXECUTE: begin
        alu_op = w_exec_aluop;
      end
      ST_MEM: begin
        mm_sel = 1'b1;
        dm_we  = w_is_str;
      end
      ST_WBACK: begin
        // Keep the ALU result stable but stop it re-saving status.
        alu_op = w_exec_aluop | ALUOP_NOSAVE;
        rf_we  = 1'b1;
        wb_sel = w_is_lod;
        mm_sel = w_is_lod;
      end
      ST_HALTED: begin
        halt = 1'b1;
      end
      default: begin
        pc_rst = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Directed bench for sisc_ctrl (default build): vector table plus HLT and reset-mid-STR sequences.
module tb_sisc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [3:0]  stat;
  logic        ir_load, pc_write, pc_rst, pc_sel, br_sel;
  logic [1:0]  alu_op;
  logic        rf_we, wb_sel, mm_sel, dm_we, halt;

  sisc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .stat     (stat),
    .ir_load  (ir_load),
    .pc_write (pc_write),
    .pc_rst   (pc_rst),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .alu_op   (alu_op),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .mm_sel   (mm_sel),
    .dm_we    (dm_we),
    .halt     (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: {ir_load,pc_write,pc_rst,pc_sel,br_sel,alu_op[1:0],rf_we,wb_sel,mm_sel,dm_we,halt}
  localparam logic [11:0] E_NONE = 12'h000;
  localparam logic [11:0] E_IRL  = 12'h800;
  localparam logic [11:0] E_PCW  = 12'h400;
  localparam logic [11:0] E_PCR  = 12'h200;
  localparam logic [11:0] E_PCS  = 12'h100;
  localparam logic [11:0] E_BRS  = 12'h080;
  localparam logic [11:0] E_A10  = 12'h040;
  localparam logic [11:0] E_A01  = 12'h020;
  localparam logic [11:0] E_A11  = 12'h060;
  localparam logic [11:0] E_RFW  = 12'h010;
  localparam logic [11:0] E_WBS  = 12'h008;
  localparam logic [11:0] E_MMS  = 12'h004;
  localparam logic [11:0] E_DMW  = 12'h002;
  localparam logic [11:0] E_HLT  = 12'h001;
  localparam logic [11:0] E_F    = E_IRL | E_PCW;

  localparam logic [31:0] I_ALU  = 32'h1000_0001;
  localparam logic [31:0] I_ADDI = 32'h2000_0003;
  localparam logic [31:0] I_BRR  = 32'h4100_0005;
  localparam logic [31:0] I_BRA  = 32'h5100_0005;
  localparam logic [31:0] I_BRA0 = 32'h5000_0000;
  localparam logic [31:0] I_BRRC = 32'h4C00_0000;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_UNK  = 32'h3000_0000;
  localparam logic [31:0] I_OP6  = 32'h6100_0000;
  localparam logic [31:0] I_LOD  = 32'h8000_0004;
  localparam logic [31:0] I_STR  = 32'h9000_0004;
  localparam logic [31:0] I_HLT  = 32'hF000_0000;

  typedef struct packed {
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  stat;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp;
  int          n_err;
  logic [11:0] w_act;

  assign w_act = {ir_load, pc_write, pc_rst, pc_sel, br_sel, alu_op,
                  rf_we, wb_sel, mm_sel, dm_we, halt};

  function automatic void add(input logic r, input logic [31:0] ins,
                              input logic [3:0] st, input logic [11:0] exp);
    vec_t v;
    v.rst   = r;
    v.instr = ins;
    v.stat  = st;
    v.exp   = exp;
    vecs.push_back(v);
  endfunction

  // Entered just after a posedge; drives the cycle's inputs, checks mid-cycle, advances one edge.
  task automatic step(input logic r, input logic [31:0] ins, input logic [3:0] st,
                      input logic [11:0] exp, input string nm);
    rst   = r;
    instr = ins;
    stat  = st;
    @(negedge clk);
    n_cmp++;
    if (w_act !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h", nm, w_act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    instr = 32'h0;
    stat  = 4'h0;

    add(0, I_NOP,  4'h0, E_PCR);
    add(0, I_NOP,  4'h0, E_PCR);
    add(0, I_ALU,  4'h0, E_F);
    add(0, I_ALU,  4'h0, E_NONE);
    add(0, I_ALU,  4'h0, E_NONE);
    add(0, I_ALU,  4'h0, E_A10 | E_RFW);
    add(0, I_ADDI, 4'h0, E_F);
    add(0, I_ADDI, 4'h0, E_NONE);
    add(0, I_ADDI, 4'h0, E_A01);
    add(0, I_ADDI, 4'h0, E_A11 | E_RFW);
    add(0, I_BRR,  4'h1, E_F);
    add(0, I_BRR,  4'h1, E_PCW | E_PCS);
    add(0, I_BRR,  4'h2, E_F);
    add(0, I_BRR,  4'h2, E_NONE);
    add(0, I_BRA,  4'h1, E_F);
    add(0, I_BRA,  4'h1, E_PCW | E_PCS | E_BRS);
    add(0, I_BRA0, 4'h0, E_F);
    add(0, I_BRA0, 4'h0, E_PCW | E_PCS | E_BRS);
    add(0, I_BRRC, 4'h8, E_F);
    add(0, I_BRRC, 4'h8, E_PCW | E_PCS);
    add(0, I_BRRC, 4'h3, E_F);
    add(0, I_BRRC, 4'h3, E_NONE);
    add(0, I_NOP,  4'hF, E_F);
    add(0, I_NOP,  4'hF, E_NONE);
    add(0, I_UNK,  4'h0, E_F);
    add(0, I_UNK,  4'h0, E_NONE);
    add(0, I_OP6,  4'h0, E_F);
    add(0, I_OP6,  4'h0, E_NONE);
    add(0, I_LOD,  4'h0, E_F);
    add(0, I_LOD,  4'h0, E_NONE);
    add(0, I_LOD,  4'h0, E_A11);
    add(0, I_LOD,  4'h0, E_MMS);
    add(0, I_LOD,  4'h0, E_A11 | E_RFW | E_WBS | E_MMS);
    add(0, I_STR,  4'h0, E_F);
    add(0, I_STR,  4'h0, E_NONE);
    add(0, I_STR,  4'h0, E_A11);
    add(0, I_STR,  4'h0, E_MMS | E_DMW);
    add(0, I_NOP,  4'h0, E_F);
    add(0, I_NOP,  4'h0, E_NONE);

    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].instr, vecs[i].stat, vecs[i].exp, $sformatf("vec%0d", i));
    end

    step(0, I_HLT, 4'h0, E_F,    "hlt_fetch");
    step(0, I_HLT, 4'h0, E_NONE, "hlt_decode");
    for (int k = 0; k < 20; k++) begin
      step(0, I_HLT, 4'h0, E_HLT, $sformatf("hlt_hold%0d", k));
    end
    step(1, I_HLT, 4'h0, E_HLT, "hlt_rst_edge");
    step(0, I_NOP, 4'h0, E_PCR, "hlt_start0");
    step(0, I_NOP, 4'h0, E_PCR, "hlt_start1");
    step(0, I_STR, 4'h0, E_F,   "rstmem_fetch");

    step(0, I_STR, 4'h0, E_NONE,        "rstmem_decode");
    step(0, I_STR, 4'h0, E_A11,         "rstmem_exec");
    step(1, I_STR, 4'h0, E_MMS | E_DMW, "rstmem_mem");
    step(0, I_STR, 4'h0, E_PCR,         "rstmem_start0");
    step(0, I_STR, 4'h0, E_PCR,         "rstmem_start1");
    step(0, I_ALU, 4'h0, E_F,           "rstmem_fetch2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
